// File: rtl/seg7_pkg.sv
// Purpose: shared constants and types for the seg7_mux display controller.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Holds the register offsets within the block's address window, the CTRL
// bit layout, and the hex-to-segment table (active-high, bit order g..a).
package seg7_pkg;

    localparam int DIGIT0_OFS = 0;
    localparam int CTRL_OFS   = 16;
    localparam int STATUS_OFS = 17;

    localparam int CTRL_RAW_BIT   = 0;
    localparam int CTRL_BLANK_BIT = 1;
    localparam int CTRL_DUTY_LSB  = 4;

    typedef struct packed {
        logic [3:0] duty;
        logic [1:0] rsvd;
        logic       blank;
        logic       raw;
    } ctrl_t;

    // Segment patterns {g,f,e,d,c,b,a}, active-high, for nibble 0..F.
    localparam logic [6:0] HEX7_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Purpose: nibble + decimal point to 8-bit segment pattern {dp,g..a}, active-high.
// Latency: combinational.
// Backpressure: none.
//
// Ports: i_nib - hex digit, i_dp - decimal point, o_seg - segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    assign o_seg = {i_dp, HEX7_TBL[i_nib]};

endmodule

// File: rtl/seg7_mux.sv
// Purpose: memory-mapped multi-digit seven-segment scan controller on the data bus.
// Latency: bus reads combinational; writes take effect on the write edge; seg/an registered (1 cycle).
// Backpressure: none; every enabled access to BASE..BASE+17 completes in its cycle.
//
// Ports: clk, reset_n (sync, active-low), enable/rw/addr/data (core data bus,
// data high-Z unless this block is read), seg {dp,g..a}, an (one-hot digit).
// Optional feature macro: SEG7_BRIGHTNESS_EN (CTRL[7:4] duty-cycle dimming of an).
module seg7_mux
    import seg7_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'h100,
    parameter int          DIGITS     = 4,
    parameter int          DIV_LOG2   = 10,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              rw,
    input  logic [31:0]       addr,
    inout  wire  [31:0]       data,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an
);

`ifdef SEG7_BRIGHTNESS_EN
    localparam logic [7:0] CTRL_WMASK = 8'((1 << CTRL_RAW_BIT) | (1 << CTRL_BLANK_BIT) |
                                           (15 << CTRL_DUTY_LSB));
`else
    localparam logic [7:0] CTRL_WMASK = 8'((1 << CTRL_RAW_BIT) | (1 << CTRL_BLANK_BIT));
`endif

    logic [7:0]          r_digit [DIGITS];
    ctrl_t               r_ctrl;
    logic [DIV_LOG2-1:0] r_presc;
    logic [3:0]          r_idx;
    logic [23:0]         r_frame;

    logic        w_hit;
    logic [4:0]  w_ofs;
    logic        w_wr;
    logic        w_rd_en;
    logic [31:0] w_rdat;
    logic [7:0]  w_cur;
    logic [7:0]  w_dec;
    logic [7:0]  w_seg_h;
    logic        w_an_on;

    assign w_hit = (addr >= BASE) && (addr <= BASE + 32'd17);
    // Only the low five bits of the offset matter once the hit range is known.
    assign w_ofs   = addr[4:0] - BASE[4:0];
    assign w_wr    = enable && rw && w_hit;
    assign w_rd_en = enable && !rw && w_hit;

    always_comb begin
        w_rdat = '0;
        if (!w_ofs[4]) begin
            for (int i = 0; i < DIGITS; i++)
                if (w_ofs[3:0] == 4'(i)) w_rdat[7:0] = r_digit[i];
        end else if (w_ofs == 5'(CTRL_OFS)) begin
            w_rdat[7:0] = r_ctrl;
        end else if (w_ofs == 5'(STATUS_OFS)) begin
            w_rdat = {r_frame, 4'b0, r_idx};
        end
    end

    assign data = w_rd_en ? w_rdat : 32'bz;

    // Value of the digit currently being scanned.
    always_comb begin
        w_cur = '0;
        for (int i = 0; i < DIGITS; i++)
            if (r_idx == 4'(i)) w_cur = r_digit[i];
    end

    seg7_hex_decode u_dec (
        .i_nib (w_cur[3:0]),
        .i_dp  (w_cur[4]),
        .o_seg (w_dec)
    );

    assign w_seg_h = r_ctrl.raw ? w_cur : w_dec;

`ifdef SEG7_BRIGHTNESS_EN
    // Dimming gates only the digit enable; the top prescaler nibble is the slot phase.
    assign w_an_on = !r_ctrl.blank && (r_presc[DIV_LOG2-1 -: 4] <= r_ctrl.duty);
`else
    assign w_an_on = !r_ctrl.blank;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DIGITS; i++) r_digit[i] <= '0;
            r_ctrl  <= '0;
            r_presc <= '0;
            r_idx   <= '0;
            r_frame <= '0;
            seg     <= {8{ACTIVE_LOW}};
            an      <= {DIGITS{ACTIVE_LOW}};
        end else begin
            r_presc <= r_presc + 1'b1;
            if (&r_presc) begin
                if (r_idx == 4'(DIGITS - 1)) begin
                    r_idx   <= '0;
                    r_frame <= r_frame + 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end

            if (w_wr) begin
                for (int i = 0; i < DIGITS; i++)
                    if (!w_ofs[4] && w_ofs[3:0] == 4'(DIGIT0_OFS + i)) r_digit[i] <= 8'(data);
                if (w_ofs == 5'(CTRL_OFS)) r_ctrl <= ctrl_t'(8'(data) & CTRL_WMASK);
            end

            // Outputs follow the pre-update index and register file.
            seg <= (r_ctrl.blank ? 8'h00 : w_seg_h) ^ {8{ACTIVE_LOW}};
            an  <= (w_an_on ? (DIGITS'(1) << r_idx) : {DIGITS{1'b0}}) ^ {DIGITS{ACTIVE_LOW}};
        end
    end

endmodule
